// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Three-channel debouncer for the front-panel push-buttons (reset, walk
// request, reprogram). Each raw button is optionally inverted, passed through
// a 2-flop synchronizer, and then filtered by a four-state FSM. The level
// flips only after the synchronized value has differed from it for
// DEBOUNCE_COUNT consecutive clock edges. A one-cycle pulse marks each
// debounced press. Releases produce no pulse.
//
// Parameters:
//   DEBOUNCE_COUNT  stable edges required before a level flips (2..2^CNT_WIDTH-1)
//   CNT_WIDTH       width of each per-channel stability counter
//   BTN_ACTIVE_LOW  1 = raw buttons read 0 when pressed
//
// Ports:
//   clk                 system clock
//   reset               asynchronous active-low power-on reset
//   reset_btn           raw reset push-button (asynchronous to clk)
//   walk_btn            raw walk push-button (asynchronous to clk)
//   reprogram_btn       raw reprogram push-button (asynchronous to clk)
//   reset_db_out        debounced reset-button level
//   walkRequest_db_out  debounced walk-button level
//   reprogram_db_out    debounced reprogram-button level
//   press_pulse[2:0]    one-cycle press pulse: [0]=reset [1]=walk [2]=reprogram
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_COUNT = 4,
  parameter int CNT_WIDTH      = 4,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_btn,
  input  logic       walk_btn,
  input  logic       reprogram_btn,
  output logic       reset_db_out,
  output logic       walkRequest_db_out,
  output logic       reprogram_db_out,
  output logic [2:0] press_pulse
);

  localparam int NUM_CH = 3;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    ARM_HIGH = 2'd1,
    HIGH     = 2'd2,
    ARM_LOW  = 2'd3
  } state_t;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  state_t            state_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [NUM_CH-1:0] level_q;
  logic [NUM_CH-1:0] pulse_q;

  // Channel order matches press_pulse: [0]=reset, [1]=walk, [2]=reprogram.
  assign raw = {reprogram_btn, walk_btn, reset_btn} ^ {NUM_CH{BTN_ACTIVE_LOW}};

  // NOTE: every state element, including the per-channel counter/state
  // arrays, is cleared by the asynchronous reset so a mid-count abort leaves
  // no stale progress; all updates here are non-blocking so the synchronizer
  // stages and FSMs see last cycle's values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= LOW;
        cnt_q[ch]   <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      pulse_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        case (state_q[ch])
          LOW: begin
            if (sync2_q[ch]) begin
              state_q[ch] <= ARM_HIGH;
              cnt_q[ch]   <= CNT_ONE;
            end
          end
          ARM_HIGH: begin
            if (!sync2_q[ch]) begin
              // Bounced back before the window completed: start over.
              state_q[ch] <= LOW;
              cnt_q[ch]   <= '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
              state_q[ch] <= HIGH;
              cnt_q[ch]   <= '0;
              level_q[ch] <= 1'b1;
              pulse_q[ch] <= 1'b1;
            end else begin
              cnt_q[ch] <= cnt_q[ch] + CNT_ONE;
            end
          end
          HIGH: begin
            if (!sync2_q[ch]) begin
              state_q[ch] <= ARM_LOW;
              cnt_q[ch]   <= CNT_ONE;
            end
          end
          ARM_LOW: begin
            if (sync2_q[ch]) begin
              state_q[ch] <= HIGH;
              cnt_q[ch]   <= '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
              state_q[ch] <= LOW;
              cnt_q[ch]   <= '0;
              level_q[ch] <= 1'b0;
            end else begin
              cnt_q[ch] <= cnt_q[ch] + CNT_ONE;
            end
          end
          default: begin
            state_q[ch] <= LOW;
            cnt_q[ch]   <= '0;
            level_q[ch] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign reset_db_out       = level_q[0];
  assign walkRequest_db_out = level_q[1];
  assign reprogram_db_out   = level_q[2];
  assign press_pulse        = pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer with DEBOUNCE_COUNT=4. Instance "a" is
// active-high, instance "b" is active-low. Inputs change #1 after a rising
// edge and outputs are sampled #1 after each rising edge, so "edge k" means
// the k-th rising edge after an input change. With a 2-flop synchronizer and
// a 4-edge window, a level flips on edge 6.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic a_reset_btn, a_walk_btn, a_reprogram_btn;
  logic a_reset_db, a_walk_db, a_reprogram_db;
  logic [2:0] a_pulse;

  logic b_reset_btn, b_walk_btn, b_reprogram_btn;
  logic b_reset_db, b_walk_db, b_reprogram_db;
  logic [2:0] b_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_COUNT(4), .CNT_WIDTH(4), .BTN_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset),
    .reset_btn(a_reset_btn), .walk_btn(a_walk_btn), .reprogram_btn(a_reprogram_btn),
    .reset_db_out(a_reset_db), .walkRequest_db_out(a_walk_db),
    .reprogram_db_out(a_reprogram_db), .press_pulse(a_pulse)
  );

  button_debouncer #(
    .DEBOUNCE_COUNT(4), .CNT_WIDTH(4), .BTN_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .reset_btn(b_reset_btn), .walk_btn(b_walk_btn), .reprogram_btn(b_reprogram_btn),
    .reset_db_out(b_reset_db), .walkRequest_db_out(b_walk_db),
    .reprogram_db_out(b_reprogram_db), .press_pulse(b_pulse)
  );

  task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  // Levels packed as {reprogram, walk, reset} to line up with press_pulse.
  task automatic expect_a(input string tag, input logic [2:0] lvl, input logic [2:0] pls);
    check({tag, " a_level"}, {5'd0, a_reprogram_db, a_walk_db, a_reset_db}, {5'd0, lvl});
    check({tag, " a_pulse"}, {5'd0, a_pulse}, {5'd0, pls});
  endtask

  task automatic expect_b(input string tag, input logic [2:0] lvl, input logic [2:0] pls);
    check({tag, " b_level"}, {5'd0, b_reprogram_db, b_walk_db, b_reset_db}, {5'd0, lvl});
    check({tag, " b_pulse"}, {5'd0, b_pulse}, {5'd0, pls});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, checking instance a holds the given outputs after each.
  task automatic run_a(input int n, input string tag, input logic [2:0] lvl, input logic [2:0] pls);
    for (int i = 0; i < n; i++) begin
      step();
      expect_a(tag, lvl, pls);
    end
  endtask

  task automatic run_b(input int n, input string tag, input logic [2:0] lvl, input logic [2:0] pls);
    for (int i = 0; i < n; i++) begin
      step();
      expect_b(tag, lvl, pls);
    end
  endtask

  initial begin
    // Reset with every active-high button held pressed; b buttons idle (1).
    a_reset_btn = 1'b1; a_walk_btn = 1'b1; a_reprogram_btn = 1'b1;
    b_reset_btn = 1'b1; b_walk_btn = 1'b1; b_reprogram_btn = 1'b1;
    reset = 1'b0;
    run_a(4, "in_reset", 3'b000, 3'b000);
    expect_b("in_reset", 3'b000, 3'b000);

    // Release reset with only walk held.
    a_reset_btn = 1'b0; a_reprogram_btn = 1'b0;
    step();
    reset = 1'b1;
    run_a(5, "por_walk_wait", 3'b000, 3'b000);
    step();
    expect_a("por_walk_edge6", 3'b010, 3'b010);
    step();
    expect_a("por_walk_edge7", 3'b010, 3'b000);

    // Release walk: falls on edge 6, never pulses.
    a_walk_btn = 1'b0;
    run_a(5, "walk_rel_wait", 3'b010, 3'b000);
    run_a(3, "walk_rel_done", 3'b000, 3'b000);

    // Bounce: 3-cycle high and low phases, twice, then held high.
    for (int k = 0; k < 2; k++) begin
      a_walk_btn = 1'b1;
      run_a(3, "bounce_hi", 3'b000, 3'b000);
      a_walk_btn = 1'b0;
      run_a(3, "bounce_lo", 3'b000, 3'b000);
    end
    a_walk_btn = 1'b1;
    run_a(5, "bounce_final_wait", 3'b000, 3'b000);
    step();
    expect_a("bounce_final_edge6", 3'b010, 3'b010);
    run_a(2, "bounce_final_hold", 3'b010, 3'b000);

    // Reprogram press, then a 3-cycle dropout that must be rejected.
    a_reprogram_btn = 1'b1;
    run_a(5, "repro_press_wait", 3'b010, 3'b000);
    step();
    expect_a("repro_press_edge6", 3'b110, 3'b100);
    step();
    a_reprogram_btn = 1'b0;
    run_a(3, "repro_glitch_lo", 3'b110, 3'b000);
    a_reprogram_btn = 1'b1;
    run_a(8, "repro_glitch_hold", 3'b110, 3'b000);

    // Real reprogram release.
    a_reprogram_btn = 1'b0;
    run_a(5, "repro_rel_wait", 3'b110, 3'b000);
    step();
    expect_a("repro_rel_edge6", 3'b010, 3'b000);
    run_a(2, "repro_rel_hold", 3'b010, 3'b000);

    // Release walk so reset_btn and walk can be pressed together.
    a_walk_btn = 1'b0;
    run_a(5, "walk_rel2_wait", 3'b010, 3'b000);
    run_a(3, "walk_rel2_done", 3'b000, 3'b000);
    a_reset_btn = 1'b1; a_walk_btn = 1'b1;
    run_a(5, "dual_wait", 3'b000, 3'b000);
    step();
    expect_a("dual_edge6", 3'b011, 3'b011);
    step();
    expect_a("dual_edge7", 3'b011, 3'b000);

    // Reprogram press aborted by reset in ARM_HIGH with cnt=2 (after edge 4).
    a_reprogram_btn = 1'b1;
    run_a(4, "abort_arm", 3'b011, 3'b000);
    reset = 1'b0;
    #1;
    expect_a("abort_async_clear", 3'b000, 3'b000);
    run_a(3, "abort_in_reset", 3'b000, 3'b000);
    reset = 1'b1;
    run_a(5, "abort_rel_wait", 3'b000, 3'b000);
    step();
    expect_a("abort_rel_edge6", 3'b111, 3'b111);
    step();
    expect_a("abort_rel_edge7", 3'b111, 3'b000);

    // Active-low instance: walk pressed by driving 0.
    expect_b("al_idle", 3'b000, 3'b000);
    b_walk_btn = 1'b0;
    run_b(5, "al_press_wait", 3'b000, 3'b000);
    step();
    expect_b("al_press_edge6", 3'b010, 3'b010);
    step();
    expect_b("al_press_edge7", 3'b010, 3'b000);
    b_walk_btn = 1'b1;
    run_b(5, "al_rel_wait", 3'b010, 3'b000);
    step();
    expect_b("al_rel_edge6", 3'b000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
